// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first, 16x oversampling, break-safe.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_STATUS,
    output logic       RX_FERR
);

    localparam int c_div = CLK_HZ / (BAUD * 16);
    localparam int c_tw  = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_tw-1:0] c_tmax = c_tw'(c_div - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic            r_sync1;
    logic            r_sync2;
    logic [c_tw-1:0] r_tcnt;
    logic [1:0]      r_state;
    logic [3:0]      r_scnt;
    logic [2:0]      r_bcnt;
    logic [7:0]      r_shreg;
    logic            r_armed;
    logic [7:0]      r_data;
    logic            r_status;
    logic            r_ferr;

    logic w_rxs;
    logic w_tick;

    assign w_rxs  = r_sync2;
    assign w_tick = (r_tcnt == c_tmax);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_tcnt   <= '0;
            r_state  <= c_st_idle;
            r_scnt   <= 4'd0;
            r_bcnt   <= 3'd0;
            r_shreg  <= 8'h00;
            r_armed  <= 1'b1;
            r_data   <= 8'h00;
            r_status <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_sync1  <= UART_RX;
            r_sync2  <= r_sync1;
            r_tcnt   <= w_tick ? '0 : r_tcnt + 1'b1;
            r_status <= 1'b0;
            r_ferr   <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    c_st_idle: begin
                        if (w_rxs) begin
                            r_armed <= 1'b1;
                        end else if (r_armed) begin
                            r_state <= c_st_start;
                            r_scnt  <= 4'd0;
                        end
                    end
                    c_st_start: begin
                        if (r_scnt != 4'd7) begin
                            r_scnt <= r_scnt + 4'd1;
                        end else if (!w_rxs) begin
                            r_state <= c_st_data;
                            r_scnt  <= 4'd0;
                            r_bcnt  <= 3'd0;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                    c_st_data: begin
                        if (r_scnt != 4'd15) begin
                            r_scnt <= r_scnt + 4'd1;
                        end else begin
                            r_shreg <= {w_rxs, r_shreg[7:1]};
                            r_scnt  <= 4'd0;
                            r_bcnt  <= r_bcnt + 3'd1;
                            if (r_bcnt == 3'd7) begin
                                r_state <= c_st_stop;
                            end
                        end
                    end
                    c_st_stop: begin
                        if (r_scnt != 4'd15) begin
                            r_scnt <= r_scnt + 4'd1;
                        end else begin
                            // Low stop bit disarms so a held-low break cannot retrigger.
                            if (w_rxs) begin
                                r_data   <= r_shreg;
                                r_status <= 1'b1;
                            end else begin
                                r_ferr  <= 1'b1;
                                r_armed <= 1'b0;
                            end
                            r_state <= c_st_idle;
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    assign RX_DATA   = r_data;
    assign RX_STATUS = r_status;
    assign RX_FERR   = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// Testbench for uart_rx: drives 8N1 frames and checks received bytes, pulses
// and timing against a frame-level model of the serial link.
module tb_uart_rx;

    localparam int c_bit = 160;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       UART_RX = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_STATUS;
    logic       RX_FERR;

    int n_cmp = 0;
    int n_err = 0;
    longint cyc = 0;
    logic [7:0] last_good = 8'h00;

    logic [7:0] stat_data[$];
    longint     stat_cyc[$];
    longint     ferr_cyc[$];

    uart_rx #(.CLK_HZ(1600000), .BAUD(10000)) dut (
        .clk(clk), .reset(reset), .UART_RX(UART_RX),
        .RX_DATA(RX_DATA), .RX_STATUS(RX_STATUS), .RX_FERR(RX_FERR)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Event monitor: records pulses and checks exclusivity and one-clock width.
    initial begin
        logic prev_s;
        logic prev_f;
        prev_s = 1'b0;
        prev_f = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (RX_STATUS) begin
                    stat_data.push_back(RX_DATA);
                    stat_cyc.push_back(cyc);
                end
                if (RX_FERR) ferr_cyc.push_back(cyc);
                if (RX_STATUS || RX_FERR) begin
                    n_cmp++;
                    if ((RX_STATUS && RX_FERR) || (RX_STATUS && prev_s) || (RX_FERR && prev_f)) begin
                        n_err++;
                        $display("FAIL pulse_shape: status=%b ferr=%b prev_status=%b prev_ferr=%b required single exclusive 1-clock pulses",
                                 RX_STATUS, RX_FERR, prev_s, prev_f);
                    end
                end
            end
            prev_s = RX_STATUS;
            prev_f = RX_FERR;
        end
    end

    task automatic idle(input int n);
        UART_RX = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output longint t0);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            UART_RX = bits[i];
            repeat (c_bit) @(posedge clk);
            #1;
        end
        UART_RX = 1'b1;
    endtask

    task automatic clear_events();
        stat_data.delete();
        stat_cyc.delete();
        ferr_cyc.delete();
    endtask

    task automatic do_reset();
        UART_RX = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        last_good = 8'h00;
        clear_events();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (RX_DATA !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", RX_DATA); end
        n_cmp++;
        if (RX_STATUS !== 1'b0) begin n_err++; $display("FAIL reset_status: got %b want 0", RX_STATUS); end
        n_cmp++;
        if (RX_FERR !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", RX_FERR); end
    endtask

    task automatic test_glitch();
        do_reset();
        idle(50);
        UART_RX = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        idle(400);
        n_cmp++;
        if (stat_cyc.size() != 0 || ferr_cyc.size() != 0) begin
            n_err++;
            $display("FAIL glitch_pulses: status=%0d ferr=%0d want 0/0", stat_cyc.size(), ferr_cyc.size());
        end
        n_cmp++;
        if (RX_DATA !== last_good) begin n_err++; $display("FAIL glitch_data: got %h want %h", RX_DATA, last_good); end
    endtask

    task automatic test_good_byte();
        longint t0;
        clear_events();
        send_frame(8'hA5, 1'b1, t0);
        last_good = 8'hA5;
        idle(200);
        n_cmp++;
        if (stat_cyc.size() != 1 || ferr_cyc.size() != 0) begin
            n_err++;
            $display("FAIL good_count: status=%0d ferr=%0d want 1/0", stat_cyc.size(), ferr_cyc.size());
        end else begin
            n_cmp++;
            if (stat_data[0] !== 8'hA5) begin n_err++; $display("FAIL good_data: got %h want a5", stat_data[0]); end
            // Start seen 2..11 clocks after the edge, pulse one clock after tick 152.
            n_cmp++;
            if (stat_cyc[0] - t0 < 1520 || stat_cyc[0] - t0 > 1535) begin
                n_err++;
                $display("FAIL good_latency: got %0d want 1520..1535", stat_cyc[0] - t0);
            end
        end
        n_cmp++;
        if (RX_DATA !== 8'hA5) begin n_err++; $display("FAIL good_hold: got %h want a5", RX_DATA); end
    endtask

    task automatic test_framing();
        longint t0;
        clear_events();
        send_frame(8'h3C, 1'b1, t0);
        last_good = 8'h3C;
        idle(100);
        send_frame(8'h81, 1'b0, t0);
        idle(300);
        n_cmp++;
        if (stat_cyc.size() != 1 || ferr_cyc.size() != 1) begin
            n_err++;
            $display("FAIL ferr_count: status=%0d ferr=%0d want 1/1", stat_cyc.size(), ferr_cyc.size());
        end else begin
            n_cmp++;
            if (stat_data[0] !== 8'h3C) begin n_err++; $display("FAIL ferr_first: got %h want 3c", stat_data[0]); end
        end
        n_cmp++;
        if (RX_DATA !== 8'h3C) begin n_err++; $display("FAIL ferr_hold: got %h want 3c", RX_DATA); end
    endtask

    task automatic test_back_to_back();
        longint t0;
        longint t1;
        clear_events();
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        last_good = 8'hFF;
        idle(200);
        n_cmp++;
        if (stat_cyc.size() != 2 || ferr_cyc.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: status=%0d ferr=%0d want 2/0", stat_cyc.size(), ferr_cyc.size());
        end else begin
            n_cmp++;
            if (stat_data[0] !== 8'h00 || stat_data[1] !== 8'hFF) begin
                n_err++;
                $display("FAIL b2b_data: got %h %h want 00 ff", stat_data[0], stat_data[1]);
            end
            n_cmp++;
            if (stat_cyc[1] - stat_cyc[0] < 1590 || stat_cyc[1] - stat_cyc[0] > 1610) begin
                n_err++;
                $display("FAIL b2b_spacing: got %0d want 1590..1610", stat_cyc[1] - stat_cyc[0]);
            end
        end
    endtask

    task automatic test_break();
        longint t0;
        clear_events();
        UART_RX = 1'b0;
        repeat (5000) @(posedge clk);
        #1;
        idle(400);
        n_cmp++;
        if (ferr_cyc.size() != 1 || stat_cyc.size() != 0) begin
            n_err++;
            $display("FAIL break_count: ferr=%0d status=%0d want 1/0", ferr_cyc.size(), stat_cyc.size());
        end
        clear_events();
        send_frame(8'h5A, 1'b1, t0);
        last_good = 8'h5A;
        idle(200);
        n_cmp++;
        if (stat_cyc.size() != 1 || stat_data[0] !== 8'h5A || RX_DATA !== 8'h5A) begin
            n_err++;
            $display("FAIL break_recover: count=%0d data=%h want 1 5a", stat_cyc.size(), RX_DATA);
        end
    endtask

    task automatic test_reset_mid();
        longint t0;
        clear_events();
        t0 = cyc;
        fork
            send_frame(8'hC3, 1'b1, t0);
            begin
                repeat (5 * c_bit + 80) @(posedge clk);
                #1;
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                last_good = 8'h00;
                n_cmp++;
                if (RX_DATA !== 8'h00 || RX_STATUS !== 1'b0 || RX_FERR !== 1'b0) begin
                    n_err++;
                    $display("FAIL midreset_outputs: data=%h status=%b ferr=%b want 00 0 0", RX_DATA, RX_STATUS, RX_FERR);
                end
            end
        join
        idle(100);
        // Only the aborted frame's span is checked; the low tail of the frame
        // after reset is a new start as far as the receiver can tell.
        n_cmp++;
        if (stat_cyc.size() != 0 || ferr_cyc.size() != 0) begin
            n_err++;
            $display("FAIL midreset_pulses: status=%0d ferr=%0d want 0/0", stat_cyc.size(), ferr_cyc.size());
        end
        idle(1500);
        clear_events();
        send_frame(8'h7E, 1'b1, t0);
        last_good = 8'h7E;
        idle(200);
        n_cmp++;
        if (stat_cyc.size() != 1 || stat_data[0] !== 8'h7E || RX_DATA !== 8'h7E) begin
            n_err++;
            $display("FAIL midreset_recover: count=%0d data=%h want 1 7e", stat_cyc.size(), RX_DATA);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        longint t0;
        clear_events();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1, t0);
            idle($urandom_range(0, 200));
        end
        last_good = exp_q[exp_q.size() - 1];
        idle(200);
        n_cmp++;
        if (stat_data.size() != exp_q.size() || ferr_cyc.size() != 0) begin
            n_err++;
            $display("FAIL rand_count: status=%0d ferr=%0d want %0d/0", stat_data.size(), ferr_cyc.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (stat_data[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rand_data[%0d]: got %h want %h", i, stat_data[i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (RX_DATA !== last_good) begin n_err++; $display("FAIL rand_hold: got %h want %h", RX_DATA, last_good); end
    endtask

    initial begin
        #1;
        test_reset();
        test_glitch();
        test_good_byte();
        test_framing();
        test_back_to_back();
        test_break();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
